// File: rtl/video_pkg.sv
// Shared types and defaults for the video fetch path.
// Holds the frame reader state enum and the raster size defaults.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    REQ,
    RETRY
  } fr_state_e;

  localparam int HDISP_DEF   = 800;
  localparam int VDISP_DEF   = 480;
  localparam int PIXEL_BYTES = 4;

endpackage

// File: rtl/frame_reader.sv
// Wishbone read master streaming a framebuffer into the pixel FIFO.
// Ports: sys_clk/sys_rst_n, enable, base_adr, wshb_* master, fifo_* write side, frame_done, err_count.
import video_pkg::*;

module frame_reader #(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  parameter int ADR_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [ADR_W-1:0] base_adr,
  output logic             wshb_cyc,
  output logic             wshb_stb,
  output logic             wshb_we,
  output logic [ADR_W-1:0] wshb_adr,
  output logic [3:0]       wshb_sel,
  output logic [2:0]       wshb_cti,
  output logic [1:0]       wshb_bte,
  input  logic [31:0]      wshb_dat_sm,
  input  logic             wshb_ack,
  input  logic             wshb_err,
  input  logic             wshb_rty,
  input  logic             fifo_wfull,
  output logic             fifo_write,
  output logic [31:0]      fifo_wdata,
  output logic             frame_done,
  output logic [15:0]      err_count
);

  localparam int NPIX   = HDISP * VDISP;
  localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PIX_SH = $clog2(PIXEL_BYTES);

  fr_state_e        state_q, state_d;
  logic [PW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [ADR_W-1:0] base_q, base_d;
  logic             fifo_write_q, fifo_write_d;
  logic [31:0]      fifo_wdata_q, fifo_wdata_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      err_count_q, err_count_d;

  logic last_pix;
  logic done;

  assign last_pix = (pix_cnt_q == PW'(NPIX - 1));
  // err and ack both terminate the access; err wins on the data
  assign done = wshb_err | wshb_ack;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    base_d       = base_q;
    fifo_write_d = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    frame_done_d = 1'b0;
    err_count_d  = err_count_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          base_d    = base_adr;
          pix_cnt_d = '0;
          state_d   = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!fifo_wfull) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (done) begin
          fifo_write_d = 1'b1;
          fifo_wdata_d = wshb_err ? 32'h0 : wshb_dat_sm;
          if (wshb_err && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end
          if (last_pix) begin
            pix_cnt_d    = '0;
            base_d       = base_adr;
            frame_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
          state_d = enable ? WAIT_SPACE : IDLE;
        end else if (wshb_rty) begin
          state_d = RETRY;
        end
      end
      RETRY: begin
        state_d = REQ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      base_q       <= '0;
      fifo_write_q <= 1'b0;
      fifo_wdata_q <= 32'h0;
      frame_done_q <= 1'b0;
      err_count_q  <= 16'h0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      base_q       <= base_d;
      fifo_write_q <= fifo_write_d;
      fifo_wdata_q <= fifo_wdata_d;
      frame_done_q <= frame_done_d;
      err_count_q  <= err_count_d;
    end
  end

  assign wshb_cyc   = (state_q == REQ);
  assign wshb_stb   = (state_q == REQ);
  assign wshb_we    = 1'b0;
  // pix_cnt only moves on termination, so the address holds through REQ
  assign wshb_adr   = base_q + (ADR_W'(pix_cnt_q) << PIX_SH);
  assign wshb_sel   = 4'hF;
  assign wshb_cti   = 3'b000;
  assign wshb_bte   = 2'b00;
  assign fifo_write = fifo_write_q;
  assign fifo_wdata = fifo_wdata_q;
  assign frame_done = frame_done_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader with a 4x2 raster.
// Random slave responses checked against a pixel-index/frame-base model.
module tb_frame_reader;

  localparam int N = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic [31:0] base_adr;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [31:0] wshb_adr;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic [31:0] wshb_dat_sm;
  logic        wshb_ack, wshb_err, wshb_rty;
  logic        fifo_wfull;
  logic        fifo_write;
  logic [31:0] fifo_wdata;
  logic        frame_done;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  int          m_pix;
  logic [31:0] m_base;
  int          m_errs;

  always #5 sys_clk = ~sys_clk;

  frame_reader #(.HDISP(4), .VDISP(2), .ADR_W(32)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .enable(enable), .base_adr(base_adr),
    .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb),
    .wshb_we(wshb_we), .wshb_adr(wshb_adr),
    .wshb_sel(wshb_sel), .wshb_cti(wshb_cti),
    .wshb_bte(wshb_bte), .wshb_dat_sm(wshb_dat_sm),
    .wshb_ack(wshb_ack), .wshb_err(wshb_err),
    .wshb_rty(wshb_rty), .fifo_wfull(fifo_wfull),
    .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
    .frame_done(frame_done), .err_count(err_count)
  );

  // Serve one access. Entered and left on a negedge.
  task automatic txn(input bit a, input bit e, input bit r,
                     input int dly, output int waited);
    logic [31:0] exp_adr, dat, exp_dat;
    bit          exp_fd;
    waited = 0;
    while (!wshb_stb && waited < 10) begin
      @(negedge sys_clk);
      waited++;
    end
    checks++;
    if (!wshb_stb) begin
      errors++;
      $display("FAIL stb_timeout: stb=%b required 1", wshb_stb);
      return;
    end
    exp_adr = m_base + 32'(m_pix * 4);
    checks++;
    if (wshb_adr !== exp_adr || wshb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL req_adr: adr=%h cyc=%b required adr=%h cyc=1",
               wshb_adr, wshb_cyc, exp_adr);
    end
    checks++;
    if ({wshb_we, wshb_sel, wshb_cti, wshb_bte} !== 10'b0_1111_000_00) begin
      errors++;
      $display("FAIL bus_const: we=%b sel=%h cti=%b bte=%b required 0/f/000/00",
               wshb_we, wshb_sel, wshb_cti, wshb_bte);
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge sys_clk);
      checks++;
      if (wshb_stb !== 1'b1 || wshb_adr !== exp_adr) begin
        errors++;
        $display("FAIL req_hold: stb=%b adr=%h required 1 %h",
                 wshb_stb, wshb_adr, exp_adr);
      end
    end
    dat = $urandom;
    wshb_dat_sm = dat;
    wshb_ack = a;
    wshb_err = e;
    wshb_rty = r;
    @(negedge sys_clk);
    wshb_ack = 1'b0;
    wshb_err = 1'b0;
    wshb_rty = 1'b0;
    wshb_dat_sm = $urandom;
    if (a || e) begin
      exp_dat = e ? 32'h0 : dat;
      exp_fd = (m_pix == N - 1);
      if (e && m_errs < 16'hFFFF) m_errs++;
      checks++;
      if (fifo_write !== 1'b1 || fifo_wdata !== exp_dat || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL push: wr=%b data=%h fd=%b required 1 %h %b",
                 fifo_write, fifo_wdata, frame_done, exp_dat, exp_fd);
      end
      m_pix++;
      if (m_pix == N) begin
        m_pix = 0;
        m_base = base_adr;
      end
    end else begin
      checks++;
      if (fifo_write !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL retry_push: wr=%b fd=%b required 0 0", fifo_write, frame_done);
      end
    end
    checks++;
    if (wshb_stb !== 1'b0 || err_count !== 16'(m_errs)) begin
      errors++;
      $display("FAIL after_term: stb=%b err_count=%0d required 0 %0d",
               wshb_stb, err_count, m_errs);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    enable = 1'b0;
    base_adr = 32'h0;
    wshb_dat_sm = 32'h0;
    wshb_ack = 1'b0;
    wshb_err = 1'b0;
    wshb_rty = 1'b0;
    fifo_wfull = 1'b0;
    m_errs = 0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({wshb_cyc, wshb_stb, fifo_write, frame_done} !== 4'b0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset: cyc=%b stb=%b wr=%b fd=%b ec=%0d required all 0",
               wshb_cyc, wshb_stb, fifo_write, frame_done, err_count);
    end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (wshb_stb !== 1'b0) begin
      errors++;
      $display("FAIL idle: stb=%b required 0", wshb_stb);
    end
  endtask

  task automatic test_startup();
    int w;
    base_adr = 32'h0000_1000;
    enable = 1'b1;
    m_base = 32'h0000_1000;
    m_pix = 0;
    @(negedge sys_clk);
    checks++;
    if (wshb_stb !== 1'b0) begin
      errors++;
      $display("FAIL start_gap: stb=%b required 0", wshb_stb);
    end
    txn(1, 0, 0, 0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL start_latency: waited=%0d required 1", w);
    end
    txn(1, 0, 0, 1, w);
  endtask

  task automatic test_retry();
    int w;
    txn(0, 0, 1, 0, w);
    for (int i = 0; i < 2; i++) begin
      txn(i == 1, 0, i == 0, 0, w);
      checks++;
      if (w != 1) begin
        errors++;
        $display("FAIL retry_gap: waited=%0d required 1", w);
      end
    end
  endtask

  task automatic test_err();
    int w;
    txn(0, 1, 0, 0, w);
    txn(1, 1, 0, 0, w);
    checks++;
    if (err_count !== 16'd2) begin
      errors++;
      $display("FAIL err_count: got=%0d required 2", err_count);
    end
  endtask

  task automatic test_full_and_frame();
    int w;
    base_adr = 32'h0000_2000;
    txn(1, 0, 0, 0, w);
    txn(1, 0, 0, 2, w);
    fifo_wfull = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      checks++;
      if (wshb_stb !== 1'b0 || fifo_write !== 1'b0) begin
        errors++;
        $display("FAIL full_hold: stb=%b wr=%b required 0 0", wshb_stb, fifo_write);
      end
    end
    fifo_wfull = 1'b0;
    txn(1, 0, 0, 0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL full_release: waited=%0d required 1", w);
    end
    @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b0 || fifo_write !== 1'b0) begin
      errors++;
      $display("FAIL fd_pulse: fd=%b wr=%b required 0 0", frame_done, fifo_write);
    end
    txn(1, 0, 0, 0, w);
    checks++;
    if (m_base !== 32'h0000_2000) begin
      errors++;
      $display("FAIL new_base: model base=%h required 2000", m_base);
    end
  endtask

  task automatic test_random();
    int w, k;
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 6);
      if (i % 7 == 3) base_adr = $urandom & 32'hFFFF_FFFC;
      case (k)
        0, 1, 2: txn(1, 0, 0, $urandom_range(0, 2), w);
        3:       txn(0, 1, 0, $urandom_range(0, 2), w);
        4:       txn(0, 0, 1, $urandom_range(0, 2), w);
        5:       txn(1, 0, 1, 0, w);
        default: txn(1, 1, 1, 0, w);
      endcase
    end
  endtask

  task automatic test_enable_drop();
    int w;
    w = 0;
    while (!wshb_stb && w < 10) begin
      @(negedge sys_clk);
      w++;
    end
    enable = 1'b0;
    txn(1, 0, 0, 0, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      checks++;
      if (wshb_stb !== 1'b0) begin
        errors++;
        $display("FAIL disabled: stb=%b required 0", wshb_stb);
      end
    end
    base_adr = 32'h0000_3000;
    enable = 1'b1;
    m_base = 32'h0000_3000;
    m_pix = 0;
    txn(1, 0, 0, 0, w);
    checks++;
    if (w != 2) begin
      errors++;
      $display("FAIL reenable_latency: waited=%0d required 2", w);
    end
  endtask

  task automatic test_reset_midreq();
    int w;
    w = 0;
    while (!wshb_stb && w < 10) begin
      @(negedge sys_clk);
      w++;
    end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({wshb_cyc, wshb_stb, fifo_write} !== 3'b0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_midreq: cyc=%b stb=%b wr=%b ec=%0d required 0 0 0 0",
               wshb_cyc, wshb_stb, fifo_write, err_count);
    end
    m_errs = 0;
    base_adr = 32'h0000_4000;
    sys_rst_n = 1'b1;
    m_base = 32'h0000_4000;
    m_pix = 0;
    txn(1, 0, 0, 0, w);
    checks++;
    if (w != 2) begin
      errors++;
      $display("FAIL restart_latency: waited=%0d required 2", w);
    end
    txn(1, 0, 0, 0, w);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_retry();
    test_err();
    test_full_and_frame();
    test_random();
    test_enable_drop();
    test_reset_midreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
